// File: rtl/dtl_arbiter_2to1.sv
// Two-master round-robin DTL arbiter onto one slave port.
// Grant is locked from command through the Last data beat.
module dtl_arbiter_2to1 #(
  parameter int INTERFACE_WIDTH       = 32,
  parameter int INTERFACE_ADDR_WIDTH  = 32,
  parameter int INTERFACE_BLOCK_WIDTH = 5,
  parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8
) (
  input  logic                             iClk,
  input  logic                             iReset,
  input  logic                             iDTL_IN0_CommandValid,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_IN0_Address,
  input  logic                             iDTL_IN0_CommandReadWrite,
  input  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_IN0_BlockSize,
  output logic                             oDTL_IN0_CommandAccept,
  input  logic                             iDTL_IN0_WriteValid,
  input  logic                             iDTL_IN0_WriteLast,
  input  logic [INTERFACE_NUM_ENABLES-1:0] iDTL_IN0_WriteEnable,
  input  logic [INTERFACE_WIDTH-1:0]       iDTL_IN0_WriteData,
  output logic                             oDTL_IN0_WriteAccept,
  output logic                             oDTL_IN0_ReadValid,
  output logic                             oDTL_IN0_ReadLast,
  output logic [INTERFACE_WIDTH-1:0]       oDTL_IN0_ReadData,
  input  logic                             iDTL_IN0_ReadAccept,
  input  logic                             iDTL_IN1_CommandValid,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_IN1_Address,
  input  logic                             iDTL_IN1_CommandReadWrite,
  input  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_IN1_BlockSize,
  output logic                             oDTL_IN1_CommandAccept,
  input  logic                             iDTL_IN1_WriteValid,
  input  logic                             iDTL_IN1_WriteLast,
  input  logic [INTERFACE_NUM_ENABLES-1:0] iDTL_IN1_WriteEnable,
  input  logic [INTERFACE_WIDTH-1:0]       iDTL_IN1_WriteData,
  output logic                             oDTL_IN1_WriteAccept,
  output logic                             oDTL_IN1_ReadValid,
  output logic                             oDTL_IN1_ReadLast,
  output logic [INTERFACE_WIDTH-1:0]       oDTL_IN1_ReadData,
  input  logic                             iDTL_IN1_ReadAccept,
  output logic                             oDTL_OUT_CommandValid,
  output logic [INTERFACE_ADDR_WIDTH-1:0]  oDTL_OUT_Address,
  output logic                             oDTL_OUT_CommandReadWrite,
  output logic [INTERFACE_BLOCK_WIDTH-1:0] oDTL_OUT_BlockSize,
  input  logic                             iDTL_OUT_CommandAccept,
  output logic                             oDTL_OUT_WriteValid,
  output logic                             oDTL_OUT_WriteLast,
  output logic [INTERFACE_NUM_ENABLES-1:0] oDTL_OUT_WriteEnable,
  output logic [INTERFACE_WIDTH-1:0]       oDTL_OUT_WriteData,
  input  logic                             iDTL_OUT_WriteAccept,
  input  logic                             iDTL_OUT_ReadValid,
  input  logic                             iDTL_OUT_ReadLast,
  input  logic [INTERFACE_WIDTH-1:0]       iDTL_OUT_ReadData,
  output logic                             oDTL_OUT_ReadAccept,
  output logic [1:0]                       oGrant,
  output logic                             oBusy
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t     rState, nState;
  logic [1:0] rGrant, nGrant;
  logic       rPrio, nPrio;
  logic       sel;

  logic                             selCv, selRw;
  logic [INTERFACE_ADDR_WIDTH-1:0]  selAddr;
  logic [INTERFACE_BLOCK_WIDTH-1:0] selBs;
  logic                             selWv, selWl, selRa;
  logic [INTERFACE_NUM_ENABLES-1:0] selWe;
  logic [INTERFACE_WIDTH-1:0]       selWd;

  // Grant is one-hot, so bit 1 alone selects master 1.
  assign sel     = rGrant[1];
  assign selCv   = sel ? iDTL_IN1_CommandValid     : iDTL_IN0_CommandValid;
  assign selRw   = sel ? iDTL_IN1_CommandReadWrite : iDTL_IN0_CommandReadWrite;
  assign selAddr = sel ? iDTL_IN1_Address          : iDTL_IN0_Address;
  assign selBs   = sel ? iDTL_IN1_BlockSize        : iDTL_IN0_BlockSize;
  assign selWv   = sel ? iDTL_IN1_WriteValid       : iDTL_IN0_WriteValid;
  assign selWl   = sel ? iDTL_IN1_WriteLast        : iDTL_IN0_WriteLast;
  assign selWe   = sel ? iDTL_IN1_WriteEnable      : iDTL_IN0_WriteEnable;
  assign selWd   = sel ? iDTL_IN1_WriteData        : iDTL_IN0_WriteData;
  assign selRa   = sel ? iDTL_IN1_ReadAccept       : iDTL_IN0_ReadAccept;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      rState <= IDLE;
      rGrant <= 2'b00;
      rPrio  <= 1'b0;
    end else begin
      rState <= nState;
      rGrant <= nGrant;
      rPrio  <= nPrio;
    end
  end

  always_comb begin
    nState = rState;
    nGrant = rGrant;
    nPrio  = rPrio;
    unique case (rState)
      IDLE: begin
        if (iDTL_IN0_CommandValid && iDTL_IN1_CommandValid) begin
          nGrant = rPrio ? 2'b10 : 2'b01;
          nState = CMD;
        end else if (iDTL_IN0_CommandValid) begin
          nGrant = 2'b01;
          nState = CMD;
        end else if (iDTL_IN1_CommandValid) begin
          nGrant = 2'b10;
          nState = CMD;
        end
      end
      CMD: begin
        // A master withdrawing its command forfeits without moving rPrio.
        if (!selCv) begin
          nState = IDLE;
          nGrant = 2'b00;
        end else if (iDTL_OUT_CommandAccept) begin
          nState = selRw ? READ : WRITE;
        end
      end
      WRITE: begin
        if (selWv && iDTL_OUT_WriteAccept && selWl) begin
          nState = IDLE;
          nGrant = 2'b00;
          nPrio  = ~sel;
        end
      end
      READ: begin
        if (iDTL_OUT_ReadValid && selRa && iDTL_OUT_ReadLast) begin
          nState = IDLE;
          nGrant = 2'b00;
          nPrio  = ~sel;
        end
      end
      default: begin
        nState = IDLE;
        nGrant = 2'b00;
      end
    endcase
  end

  always_comb begin
    oDTL_OUT_CommandValid     = 1'b0;
    oDTL_OUT_Address          = '0;
    oDTL_OUT_CommandReadWrite = 1'b0;
    oDTL_OUT_BlockSize        = '0;
    oDTL_OUT_WriteValid       = 1'b0;
    oDTL_OUT_WriteLast        = 1'b0;
    oDTL_OUT_WriteEnable      = '0;
    oDTL_OUT_WriteData        = '0;
    oDTL_OUT_ReadAccept       = 1'b0;
    oDTL_IN0_CommandAccept    = 1'b0;
    oDTL_IN1_CommandAccept    = 1'b0;
    oDTL_IN0_WriteAccept      = 1'b0;
    oDTL_IN1_WriteAccept      = 1'b0;
    oDTL_IN0_ReadValid        = 1'b0;
    oDTL_IN1_ReadValid        = 1'b0;
    oDTL_IN0_ReadLast         = 1'b0;
    oDTL_IN1_ReadLast         = 1'b0;
    oDTL_IN0_ReadData         = '0;
    oDTL_IN1_ReadData         = '0;
    unique case (rState)
      CMD: begin
        oDTL_OUT_CommandValid     = selCv;
        oDTL_OUT_Address          = selAddr;
        oDTL_OUT_CommandReadWrite = selRw;
        oDTL_OUT_BlockSize        = selBs;
        oDTL_IN0_CommandAccept    = rGrant[0] & iDTL_OUT_CommandAccept;
        oDTL_IN1_CommandAccept    = rGrant[1] & iDTL_OUT_CommandAccept;
      end
      WRITE: begin
        oDTL_OUT_WriteValid  = selWv;
        oDTL_OUT_WriteLast   = selWl;
        oDTL_OUT_WriteEnable = selWe;
        oDTL_OUT_WriteData   = selWd;
        oDTL_IN0_WriteAccept = rGrant[0] & iDTL_OUT_WriteAccept;
        oDTL_IN1_WriteAccept = rGrant[1] & iDTL_OUT_WriteAccept;
      end
      READ: begin
        oDTL_OUT_ReadAccept = selRa;
        oDTL_IN0_ReadValid  = rGrant[0] & iDTL_OUT_ReadValid;
        oDTL_IN1_ReadValid  = rGrant[1] & iDTL_OUT_ReadValid;
        oDTL_IN0_ReadLast   = rGrant[0] & iDTL_OUT_ReadLast;
        oDTL_IN1_ReadLast   = rGrant[1] & iDTL_OUT_ReadLast;
        oDTL_IN0_ReadData   = rGrant[0] ? iDTL_OUT_ReadData : '0;
        oDTL_IN1_ReadData   = rGrant[1] ? iDTL_OUT_ReadData : '0;
      end
      default: begin
      end
    endcase
  end

  assign oGrant = rGrant;
  assign oBusy  = (rState != IDLE);

endmodule

// File: tb/tb_dtl_arbiter_2to1.sv
// Scoreboard bench for dtl_arbiter_2to1: directed masters,
// a scripted slave, and a negedge monitor popping expectations.
`timescale 1ns/1ps
module tb_dtl_arbiter_2to1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mCv[2], mRw[2], mWv[2], mWl[2], mRa[2];
  logic [31:0] mAddr[2], mWd[2];
  logic [4:0]  mBs[2];
  logic [3:0]  mWe[2];
  logic        cmdAcc[2], wrAcc[2], rdV[2], rdL[2];
  logic [31:0] rdD[2];

  logic        oCv, oRw, oWv, oWl, oRa;
  logic [31:0] oAddr, oWd;
  logic [4:0]  oBs;
  logic [3:0]  oWe;
  logic        sCa, sWa, sRv, sRl;
  logic [31:0] sRd;
  logic [1:0]  grant;
  logic        busy;

  logic [31:0] gapMask;
  logic [63:0] expCmd[$], expWr[$], expRd[$];
  int nChecks = 0;
  int nPass = 0;

  dtl_arbiter_2to1 dut (
    .iClk(clk), .iReset(rst),
    .iDTL_IN0_CommandValid(mCv[0]), .iDTL_IN0_Address(mAddr[0]),
    .iDTL_IN0_CommandReadWrite(mRw[0]), .iDTL_IN0_BlockSize(mBs[0]),
    .oDTL_IN0_CommandAccept(cmdAcc[0]),
    .iDTL_IN0_WriteValid(mWv[0]), .iDTL_IN0_WriteLast(mWl[0]),
    .iDTL_IN0_WriteEnable(mWe[0]), .iDTL_IN0_WriteData(mWd[0]),
    .oDTL_IN0_WriteAccept(wrAcc[0]),
    .oDTL_IN0_ReadValid(rdV[0]), .oDTL_IN0_ReadLast(rdL[0]),
    .oDTL_IN0_ReadData(rdD[0]), .iDTL_IN0_ReadAccept(mRa[0]),
    .iDTL_IN1_CommandValid(mCv[1]), .iDTL_IN1_Address(mAddr[1]),
    .iDTL_IN1_CommandReadWrite(mRw[1]), .iDTL_IN1_BlockSize(mBs[1]),
    .oDTL_IN1_CommandAccept(cmdAcc[1]),
    .iDTL_IN1_WriteValid(mWv[1]), .iDTL_IN1_WriteLast(mWl[1]),
    .iDTL_IN1_WriteEnable(mWe[1]), .iDTL_IN1_WriteData(mWd[1]),
    .oDTL_IN1_WriteAccept(wrAcc[1]),
    .oDTL_IN1_ReadValid(rdV[1]), .oDTL_IN1_ReadLast(rdL[1]),
    .oDTL_IN1_ReadData(rdD[1]), .iDTL_IN1_ReadAccept(mRa[1]),
    .oDTL_OUT_CommandValid(oCv), .oDTL_OUT_Address(oAddr),
    .oDTL_OUT_CommandReadWrite(oRw), .oDTL_OUT_BlockSize(oBs),
    .iDTL_OUT_CommandAccept(sCa),
    .oDTL_OUT_WriteValid(oWv), .oDTL_OUT_WriteLast(oWl),
    .oDTL_OUT_WriteEnable(oWe), .oDTL_OUT_WriteData(oWd),
    .iDTL_OUT_WriteAccept(sWa),
    .iDTL_OUT_ReadValid(sRv), .iDTL_OUT_ReadLast(sRl),
    .iDTL_OUT_ReadData(sRd), .oDTL_OUT_ReadAccept(oRa),
    .oGrant(grant), .oBusy(busy)
  );

  function automatic logic [63:0] cmdE(logic [1:0] g, logic rw,
                                       logic [4:0] bs, logic [31:0] a);
    return {24'b0, g, rw, bs, a};
  endfunction

  function automatic logic [63:0] wrE(logic [1:0] g, logic l,
                                      logic [3:0] e, logic [31:0] d);
    return {25'b0, g, l, e, d};
  endfunction

  function automatic logic [63:0] rdE(logic m, logic l, logic [31:0] d);
    return {30'b0, m, l, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes pop the scoreboard, plus per-cycle isolation.
  always @(negedge clk) begin
    if (!rst) begin
      if (oCv && sCa) begin
        if (expCmd.size() == 0) chk("cmd_unexpected", 1, 0);
        else chk("cmd", cmdE(grant, oRw, oBs, oAddr), expCmd.pop_front());
      end
      if (oWv && sWa) begin
        if (expWr.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr", wrE(grant, oWl, oWe, oWd), expWr.pop_front());
      end
      for (int m = 0; m < 2; m++) begin
        if (rdV[m] && mRa[m]) begin
          if (expRd.size() == 0) chk("rd_unexpected", 1, 0);
          else chk("rd", rdE(m[0], rdL[m], rdD[m]), expRd.pop_front());
        end
        if (!grant[m])
          chk("isolation", {cmdAcc[m], wrAcc[m], rdV[m], rdL[m], |rdD[m]}, 0);
      end
      chk("busy_vs_grant", busy, |grant);
    end
  end

  // Slave read side: beats are base+index, gaps from gapMask.
  initial begin
    int n, beat, cyc;
    sRv = 0; sRl = 0; sRd = '0;
    forever begin
      @(negedge clk);
      if (oCv && sCa && oRw) begin
        n = int'(oBs) + 1;
        beat = 0;
        cyc = 0;
        tick();
        while (beat < n && cyc < 64) begin
          if (gapMask[cyc[4:0]] && cyc < 32) begin
            sRv = 0; sRl = 0; sRd = '0;
          end else begin
            sRv = 1; sRl = (beat == n - 1); sRd = 32'hA000_0000 + beat;
          end
          @(negedge clk);
          if (sRv && oRa) beat++;
          tick();
          cyc++;
        end
        sRv = 0; sRl = 0; sRd = '0;
      end
    end
  end

  task automatic doCmd(input int m, input logic [31:0] a, input logic rw,
                       input logic [4:0] bs, output bit ok);
    mCv[m] = 1; mAddr[m] = a; mRw[m] = rw; mBs[m] = bs;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmdAcc[m]) ok = 1;
      tick();
    end
    mCv[m] = 0;
    if (!ok) chk("cmd_timeout", 0, 1);
  endtask

  task automatic doWrite(input int m, input int n, input logic [31:0] wb);
    bit got;
    for (int b = 0; b < n; b++) begin
      mWv[m] = 1; mWd[m] = wb + b; mWl[m] = (b == n - 1); mWe[m] = 4'hF;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk);
        if (wrAcc[m]) got = 1;
        tick();
      end
      if (!got) chk("wr_timeout", 0, 1);
    end
    mWv[m] = 0; mWl[m] = 0;
  endtask

  task automatic doRead(input int m, input int n, input logic [31:0] raMask);
    int beat = 0;
    int cyc = 0;
    while (beat < n && cyc < 64) begin
      mRa[m] = (cyc < 32) ? !raMask[cyc[4:0]] : 1'b1;
      @(negedge clk);
      if (rdV[m] && mRa[m]) beat++;
      tick();
      cyc++;
    end
    mRa[m] = 0;
    if (beat != n) chk("rd_timeout", 0, 1);
  endtask

  task automatic xact(input int m, input logic [31:0] a, input logic rw,
                      input logic [4:0] bs, input int n,
                      input logic [31:0] wb, input logic [31:0] raMask);
    bit ok;
    doCmd(m, a, rw, bs, ok);
    if (!ok) return;
    if (rw) doRead(m, n, raMask);
    else doWrite(m, n, wb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int m = 0; m < 2; m++) begin
      mCv[m] = 0; mRw[m] = 0; mWv[m] = 0; mWl[m] = 0; mRa[m] = 0;
      mAddr[m] = '0; mWd[m] = '0; mBs[m] = '0; mWe[m] = '0;
    end
    sCa = 1; sWa = 1; gapMask = '0;
    rst = 1;
    tick(); tick();
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {oCv, oWv, oRa, cmdAcc[0], cmdAcc[1]}, 0);
    tick();
    rst = 0;

    // Single zero-wait write from M0.
    expCmd.push_back(cmdE(2'b01, 0, 0, 32'h40));
    expWr.push_back(wrE(2'b01, 1, 4'hF, 32'hDEAD_BEEF));
    mCv[0] = 1; mAddr[0] = 32'h40; mRw[0] = 0; mBs[0] = 0;
    mWv[0] = 1; mWl[0] = 1; mWe[0] = 4'hF; mWd[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_idle_grant", grant, 0);
    tick();
    @(negedge clk);
    chk("t1_cmd_grant", grant, 2'b01);
    chk("t1_cmd_valid", oCv, 1);
    tick();
    mCv[0] = 0;
    @(negedge clk);
    chk("t1_wr_valid", oWv, 1);
    chk("t1_wr_cmdv", oCv, 0);
    tick();
    mWv[0] = 0; mWl[0] = 0;
    @(negedge clk);
    chk("t1_done_busy", busy, 0);
    tick();

    // rPrio is now 1: M1 wins the tie.
    expCmd.push_back(cmdE(2'b10, 0, 0, 32'h48));
    expWr.push_back(wrE(2'b10, 1, 4'hF, 32'h0B0B));
    expCmd.push_back(cmdE(2'b01, 0, 0, 32'h44));
    expWr.push_back(wrE(2'b01, 1, 4'hF, 32'h0A0A));
    fork
      xact(0, 32'h44, 0, 0, 1, 32'h0A0A, 0);
      xact(1, 32'h48, 0, 0, 1, 32'h0B0B, 0);
    join

    // After reset M0 read beats M1 write; then M0 wins again.
    rst = 1;
    tick();
    rst = 0;
    expCmd.push_back(cmdE(2'b01, 1, 0, 32'h100));
    expCmd.push_back(cmdE(2'b10, 0, 0, 32'h200));
    expRd.push_back(rdE(0, 1, 32'hA000_0000));
    expWr.push_back(wrE(2'b10, 1, 4'hF, 32'h1111_0000));
    fork
      xact(0, 32'h100, 1, 0, 1, 0, 0);
      xact(1, 32'h200, 0, 0, 1, 32'h1111_0000, 0);
    join
    expCmd.push_back(cmdE(2'b01, 0, 0, 32'h300));
    expCmd.push_back(cmdE(2'b10, 0, 0, 32'h304));
    expWr.push_back(wrE(2'b01, 1, 4'hF, 32'h33));
    expWr.push_back(wrE(2'b10, 1, 4'hF, 32'h34));
    fork
      xact(0, 32'h300, 0, 0, 1, 32'h33, 0);
      xact(1, 32'h304, 0, 0, 1, 32'h34, 0);
    join

    // M1 4-beat read with slave gaps and master backpressure.
    gapMask = 32'h25;
    expCmd.push_back(cmdE(2'b10, 1, 3, 32'h400));
    expRd.push_back(rdE(1, 0, 32'hA000_0000));
    expRd.push_back(rdE(1, 0, 32'hA000_0001));
    expRd.push_back(rdE(1, 0, 32'hA000_0002));
    expRd.push_back(rdE(1, 1, 32'hA000_0003));
    xact(1, 32'h400, 1, 3, 4, 0, 32'h18);
    @(negedge clk);
    chk("t3_done_busy", busy, 0);
    tick();
    gapMask = '0;

    // Early write data held off until the command is accepted.
    expCmd.push_back(cmdE(2'b01, 0, 0, 32'h500));
    expWr.push_back(wrE(2'b01, 1, 4'hF, 32'hCAFE_F00D));
    sCa = 0;
    mCv[0] = 1; mAddr[0] = 32'h500; mRw[0] = 0; mBs[0] = 0;
    mWv[0] = 1; mWl[0] = 1; mWe[0] = 4'hF; mWd[0] = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_early_outwv", oWv, 0);
      chk("t4_early_wacc", wrAcc[0], 0);
      tick();
    end
    sCa = 1;
    @(negedge clk);
    tick();
    mCv[0] = 0;
    @(negedge clk);
    chk("t4_write_pass", oWv, 1);
    tick();
    mWv[0] = 0; mWl[0] = 0;
    tick();

    // Reset in the middle of a 4-beat write.
    expCmd.push_back(cmdE(2'b01, 0, 3, 32'h600));
    expWr.push_back(wrE(2'b01, 0, 4'hF, 32'h60));
    expWr.push_back(wrE(2'b01, 0, 4'hF, 32'h61));
    doCmd(0, 32'h600, 0, 3, ok);
    for (int b = 0; b < 2; b++) begin
      mWv[0] = 1; mWl[0] = 0; mWe[0] = 4'hF; mWd[0] = 32'h60 + b;
      @(negedge clk);
      tick();
    end
    mWd[0] = 32'h62; sWa = 0; rst = 1;
    tick();
    @(negedge clk);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_outs", {oCv, oWv, oRa, wrAcc[0], cmdAcc[0]}, 0);
    tick();
    rst = 0; mWv[0] = 0; sWa = 1;
    expCmd.push_back(cmdE(2'b10, 0, 0, 32'h700));
    expWr.push_back(wrE(2'b10, 1, 4'hF, 32'h70));
    xact(1, 32'h700, 0, 0, 1, 32'h70, 0);

    // M0 withdraws in CMD; rPrio must stay 0.
    sCa = 0;
    mCv[0] = 1; mAddr[0] = 32'h800; mRw[0] = 0; mBs[0] = 0;
    @(negedge clk);
    chk("t6_idle_grant", grant, 0);
    tick();
    @(negedge clk);
    chk("t6_cmd_grant", grant, 2'b01);
    tick();
    mCv[0] = 0;
    @(negedge clk);
    chk("t6_drop_cmdv", oCv, 0);
    tick();
    @(negedge clk);
    chk("t6_back_idle", {busy, grant}, 0);
    tick();
    sCa = 1;
    expCmd.push_back(cmdE(2'b01, 0, 0, 32'h810));
    expCmd.push_back(cmdE(2'b10, 0, 0, 32'h814));
    expWr.push_back(wrE(2'b01, 1, 4'hF, 32'h81));
    expWr.push_back(wrE(2'b10, 1, 4'hF, 32'h82));
    fork
      xact(0, 32'h810, 0, 0, 1, 32'h81, 0);
      xact(1, 32'h814, 0, 0, 1, 32'h82, 0);
    join
    tick(); tick();

    chk("left_cmd", expCmd.size(), 0);
    chk("left_wr", expWr.size(), 0);
    chk("left_rd", expRd.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
